// File: rtl/mac_result_drain.sv
// Captures all N MAC cell results on start and clears the array. Optional ReLU at capture.
// Words stream out one per handshake, index 0 first. The first word is valid the cycle after start.
// out_valid and out_data depend only on registered state, so out_ready has no combinational path to them.
module mac_result_drain #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 relu_en,
  input  logic [N*W-1:0]       results,
  output logic                 mac_clr,
  output logic                 busy,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          mac_clr_q, mac_clr_d;
  logic [W-1:0]  frame_q [N];
  logic [W-1:0]  frame_d [N];
  logic          capture;

  // Next-state logic: capture on start when idle or on the final handshake, otherwise advance on handshake
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mac_clr_d = 1'b0;
    capture   = 1'b0;
    for (int k = 0; k < N; k++) begin
      frame_d[k] = frame_q[k];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + ONE_IDX;
          end else if (start) begin
            // Back-to-back frame: the new index 0 follows with no bubble
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d   = SEND;
      idx_d     = '0;
      mac_clr_d = 1'b1;
      for (int k = 0; k < N; k++) begin
        // Negative words are stored as zero when ReLU is requested for this frame
        frame_d[k] = (relu_en && results[k*W + W - 1]) ? '0 : results[k*W +: W];
      end
    end
  end

  // State, index and clear-pulse registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mac_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mac_clr_q <= mac_clr_d;
    end
  end

  // Frame buffer; contents are ignored outside SEND, so it needs no reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      frame_q[k] <= frame_d[k];
    end
  end

  // Outputs are decoded from registered state only
  always_comb begin
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    out_index = idx_q;
    out_data  = (state_q == SEND) ? frame_q[idx_q] : '0;
    out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    mac_clr   = mac_clr_q;
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain with N=4.
// Directed vector table, randomized backpressure against a queue model, and hand-written corner sequences.
module tb_mac_result_drain;

  localparam int N = 4;
  localparam int W = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 relu_en;
  logic [N*W-1:0]       results;
  logic                 mac_clr;
  logic                 busy;
  logic [W-1:0]         out_data;
  logic [$clog2(N)-1:0] out_index;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  mac_result_drain #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .relu_en   (relu_en),
    .results   (results),
    .mac_clr   (mac_clr),
    .busy      (busy),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef logic [N-1:0][W-1:0] frame_t;

  typedef struct packed {
    frame_t words;
    logic   relu;
    frame_t expd;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ReLU in signed arithmetic terms
  function automatic logic [W-1:0] relu_model(input logic [W-1:0] x, input logic en);
    if (en && ($signed(x) < 0)) return '0;
    return x;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input frame_t w, input logic rl);
    results = w;
    relu_en = rl;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    relu_en = ~rl;
    results = {$urandom, $urandom, $urandom, $urandom};
  endtask

  vec_t       vecs [4];
  frame_t     fa, fb, fc, fr;
  logic       rl;
  logic [W-1:0] expq [$];
  int         e_idx;
  int         cyc;
  logic       hs;

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; results = '0; out_ready = 1'b0;

    vecs[0] = '{words: {32'h7FFFFFFF, 32'h00008000, 32'hFFFF0000, 32'h00010000}, relu: 1'b0,
                expd:  {32'h7FFFFFFF, 32'h00008000, 32'hFFFF0000, 32'h00010000}};
    vecs[1] = '{words: {32'h7FFFFFFF, 32'h00008000, 32'hFFFF0000, 32'h00010000}, relu: 1'b1,
                expd:  {32'h7FFFFFFF, 32'h00008000, 32'h00000000, 32'h00010000}};
    vecs[2] = '{words: {32'h00000001, 32'h80000001, 32'h00000000, 32'h80000000}, relu: 1'b1,
                expd:  {32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000}};
    vecs[3] = '{words: {32'h00000001, 32'h80000001, 32'h12345678, 32'h80000000}, relu: 1'b0,
                expd:  {32'h00000001, 32'h80000001, 32'h12345678, 32'h80000000}};

    // Reset state
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_clr",   {31'd0, mac_clr}, 32'd0);
    chk("rst_index", {30'd0, out_index}, 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_last",  {31'd0, out_last}, 32'd0);

    // start during reset must not capture
    results = vecs[0].words;
    start = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rststart_valid", {31'd0, out_valid}, 32'd0);
    chk("rststart_clr",   {31'd0, mac_clr}, 32'd0);
    tick();
    chk("rststart_valid2", {31'd0, out_valid}, 32'd0);

    // Directed table: full-rate drain
    out_ready = 1'b1;
    foreach (vecs[v]) begin
      start_frame(vecs[v].words, vecs[v].relu);
      for (int k = 0; k < N; k++) begin
        chk("tbl_valid", {31'd0, out_valid}, 32'd1);
        chk("tbl_busy",  {31'd0, busy}, 32'd1);
        chk("tbl_index", {30'd0, out_index}, k);
        chk("tbl_data",  out_data, vecs[v].expd[k]);
        chk("tbl_last",  {31'd0, out_last}, (k == N-1) ? 32'd1 : 32'd0);
        chk("tbl_clr",   {31'd0, mac_clr}, (k == 0) ? 32'd1 : 32'd0);
        tick();
      end
      chk("tbl_end_valid", {31'd0, out_valid}, 32'd0);
      chk("tbl_end_busy",  {31'd0, busy}, 32'd0);
      chk("tbl_end_clr",   {31'd0, mac_clr}, 32'd0);
      tick();
    end

    // Randomized frames with random backpressure against a queue model
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < N; k++) fr[k] = $urandom;
      rl = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) expq.push_back(relu_model(fr[k], rl));
      out_ready = 1'b0;
      start_frame(fr, rl);
      e_idx = 0;
      cyc = 0;
      while (expq.size() > 0 && cyc < 200) begin
        chk("rnd_valid", {31'd0, out_valid}, 32'd1);
        chk("rnd_index", {30'd0, out_index}, e_idx);
        chk("rnd_data",  out_data, expq[0]);
        chk("rnd_last",  {31'd0, out_last}, (e_idx == N-1) ? 32'd1 : 32'd0);
        out_ready = 1'($urandom_range(0, 1));
        hs = out_valid && out_ready;
        tick();
        if (hs) begin
          void'(expq.pop_front());
          e_idx++;
        end
        cyc++;
      end
      chk("rnd_timeout", expq.size(), 32'd0);
      expq.delete();
      chk("rnd_end_busy", {31'd0, busy}, 32'd0);
      out_ready = 1'b0;
      tick();
    end

    // start while busy is ignored; start on the final handshake chains a new frame
    out_ready = 1'b1;
    fa = {32'hA0000003, 32'hA0000002, 32'h0A000001, 32'h0A000000};
    fb = {32'h0B000003, 32'h0B000002, 32'h0B000001, 32'h0B000000};
    start_frame(fa, 1'b0);
    tick();
    chk("bb_idx1", {30'd0, out_index}, 32'd1);
    results = fb; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bb_ign_idx",  {30'd0, out_index}, 32'd2);
    chk("bb_ign_data", out_data, fa[2]);
    chk("bb_ign_clr",  {31'd0, mac_clr}, 32'd0);
    tick();
    chk("bb_last", {31'd0, out_last}, 32'd1);
    chk("bb_last_data", out_data, fa[3]);
    results = fb; relu_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bb_new_valid", {31'd0, out_valid}, 32'd1);
    chk("bb_new_idx",   {30'd0, out_index}, 32'd0);
    chk("bb_new_data",  out_data, fb[0]);
    chk("bb_new_clr",   {31'd0, mac_clr}, 32'd1);
    tick();
    chk("bb_clr_once", {31'd0, mac_clr}, 32'd0);
    chk("bb_data1",    out_data, fb[1]);
    tick(); tick(); tick();
    chk("bb_end_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a frame
    start_frame(fa, 1'b0);
    tick(); tick();
    chk("mid_idx2", {30'd0, out_index}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_busy",  {31'd0, busy}, 32'd0);
    chk("mid_index", {30'd0, out_index}, 32'd0);
    chk("mid_data",  out_data, 32'd0);
    fc = {32'h00000004, 32'hC0000000, 32'h00020000, 32'hFFFFFFFF};
    start_frame(fc, 1'b1);
    for (int k = 0; k < N; k++) begin
      chk("mid_new_index", {30'd0, out_index}, k);
      chk("mid_new_data",  out_data, relu_model(fc[k], 1'b1));
      tick();
    end
    chk("mid_new_end", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
